code_verifier_seq: RTL and testbench

Parametrised, sequential successor to the safe-lock combinational code comparator. It captures a user-entered code and the scrambled stored passcode, unscrambles the stored code by digit rotation, and compares the two one digit per cycle. It counts consecutive failed attempts and enters a timed lockout after too many failures. It sits between the input shift register / stored code register and the lock controller FSM.

---
 rtl/code_verifier_seq.sv | 156 +++++++++++++++
 tb/tb_code_verifier_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/code_verifier_seq.sv
// Sequential passcode verifier: unscrambles the stored code, compares one digit per cycle,
// tracks consecutive failures and enforces a timed lockout.
module code_verifier_seq #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int ROT            = 1,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                check_req,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]       input_code,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]       stored_code,
    input  logic                                clear_attempts,
    output logic                                busy,
    output logic                                done,
    output logic                                match,
    output logic                                fail,
    output logic                                rejected,
    output logic                                locked,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts
);
    localparam int CW = NUM_DIGITS * DIGIT_W;
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [AW-1:0] MAX_A  = AW'(MAX_ATTEMPTS);
    localparam logic [IW-1:0] LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [TW-1:0] LOCK_T = TW'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COMPARE, RESULT, LOCKED} state_t;

    state_t                             state_q, state_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] in_q, in_d, ref_q, ref_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic                               eq_q, eq_d;
    logic [TW-1:0]                      tmr_q, tmr_d;
    logic [AW-1:0]                      att_q, att_d;
    logic busy_q, busy_d, done_q, done_d, match_q, match_d;
    logic fail_q, fail_d, rej_q, rej_d, lock_q, lock_d;

    logic [2*CW-1:0] dbl;
    logic [CW-1:0]   unscr;
    logic [IW-1:0]   sel;
    logic            dig_eq;

    // Right rotation taken from the doubled word so ROT=0 needs no special case.
    assign dbl    = {stored_code, stored_code};
    assign unscr  = dbl[ROT*DIGIT_W +: CW];
    assign sel    = LAST - idx_q;
    assign dig_eq = (in_q[sel] == ref_q[sel]);

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        ref_d   = ref_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        tmr_d   = tmr_q;
        att_d   = att_q;
        done_d  = 1'b0;
        match_d = 1'b0;
        fail_d  = 1'b0;
        rej_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_attempts) att_d = '0;
                if (check_req) begin
                    in_d    = input_code;
                    ref_d   = unscr;
                    idx_d   = '0;
                    eq_d    = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                eq_d  = eq_q & dig_eq;
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = RESULT;
                    done_d  = 1'b1;
                    match_d = eq_d;
                    fail_d  = ~eq_d;
                end
            end
            RESULT: begin
                if (eq_q) begin
                    att_d   = '0;
                    state_d = IDLE;
                end else begin
                    att_d = att_q + AW'(1);
                    if (att_d == MAX_A) begin
                        tmr_d   = LOCK_T;
                        state_d = LOCKED;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKED: begin
                rej_d = check_req;
                if (tmr_q == TW'(1)) begin
                    state_d = IDLE;
                    att_d   = '0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            in_q    <= '0;
            ref_q   <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            tmr_q   <= '0;
            att_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            fail_q  <= 1'b0;
            rej_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            tmr_q   <= tmr_d;
            att_q   <= att_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
            fail_q  <= fail_d;
            rej_q   <= rej_d;
            lock_q  <= lock_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign match    = match_q;
    assign fail     = fail_q;
    assign rejected = rej_q;
    assign locked   = lock_q;
    assign attempts = att_q;
endmodule

// File: tb/tb_code_verifier_seq.sv
// Directed bench for code_verifier_seq: default instance plus a 6-digit, ROT=2,
// single-attempt instance.
module tb_code_verifier_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 1'b0, a_clr = 1'b0;
    logic [15:0] a_in = '0, a_st = '0;
    logic        a_busy, a_done, a_match, a_fail, a_rej, a_locked;
    logic [1:0]  a_att;

    logic        b_req = 1'b0, b_clr = 1'b0;
    logic [23:0] b_in = '0, b_st = '0;
    logic        b_busy, b_done, b_match, b_fail, b_rej, b_locked;
    logic [0:0]  b_att;

    int n_chk = 0;
    int n_err = 0;

    code_verifier_seq dut_a (
        .clk(clk), .rst_n(rst_n), .check_req(a_req), .input_code(a_in), .stored_code(a_st),
        .clear_attempts(a_clr), .busy(a_busy), .done(a_done), .match(a_match), .fail(a_fail),
        .rejected(a_rej), .locked(a_locked), .attempts(a_att)
    );

    code_verifier_seq #(.NUM_DIGITS(6), .DIGIT_W(4), .ROT(2), .MAX_ATTEMPTS(1), .LOCKOUT_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .check_req(b_req), .input_code(b_in), .stored_code(b_st),
        .clear_attempts(b_clr), .busy(b_busy), .done(b_done), .match(b_match), .fail(b_fail),
        .rejected(b_rej), .locked(b_locked), .attempts(b_att)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request on instance A; returns at the negedge after the result cycle.
    task automatic req_a(input logic [15:0] ic, input logic [15:0] sc, input logic exp_m,
                         input logic corrupt);
        a_in = ic; a_st = sc; a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0; a_clr = 1'b0;
        if (corrupt) begin a_in = 16'hFFFF; a_st = 16'hFFFF; end
        for (int k = 1; k <= 5; k++) begin
            chk("a_busy", a_busy, 1);
            if (k == 5) begin
                chk("a_done", a_done, 1);
                chk("a_match", a_match, exp_m);
                chk("a_fail", a_fail, !exp_m);
            end else begin
                chk("a_done_early", a_done, 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic req_b(input logic [23:0] ic, input logic [23:0] sc, input logic exp_m);
        b_in = ic; b_st = sc; b_req = 1'b1;
        @(negedge clk);
        b_req = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            chk("b_busy", b_busy, 1);
            chk("b_done", b_done, (k == 7));
            if (k == 7) begin
                chk("b_match", b_match, exp_m);
                chk("b_fail", b_fail, !exp_m);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int nl, nr, nd;
        repeat (2) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_match", a_match, 0);
        chk("rst_fail", a_fail, 0);
        chk("rst_rej", a_rej, 0);
        chk("rst_locked", a_locked, 0);
        chk("rst_att", a_att, 0);
        chk("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic match
        req_a(16'h1234, 16'h2341, 1'b1, 1'b0);
        chk("t1_att", a_att, 0);
        chk("t1_idle", a_busy, 0);
        chk("t1_done_gone", a_done, 0);

        // three fails lock, check_req held during lockout
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        chk("t2_att1", a_att, 1);
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        chk("t2_att2", a_att, 2);
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        chk("t2_att3", a_att, 3);
        chk("t2_locked", a_locked, 1);
        nl = 0; nr = 0; nd = 0;
        for (int i = 0; i < 30; i++) begin
            nr += int'(a_rej);
            nd += int'(a_done);
            if (a_locked) begin
                nl++;
                a_req = 1'b1;
            end else begin
                a_req = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("t3_lock_len", nl, 8);
        chk("t3_rej_cnt", nr, 8);
        chk("t3_no_done", nd, 0);
        chk("t3_att0", a_att, 0);
        @(negedge clk);
        chk("t3_idle", a_busy, 0);
        chk("t3_rej_end", a_rej, 0);

        // two fails then match; two fails then clear
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        req_a(16'h0000, 16'h2341, 1'b0, 1'b0);
        chk("t4_att2", a_att, 2);
        req_a(16'h1234, 16'h2341, 1'b1, 1'b0);
        chk("t4_match_att0", a_att, 0);
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        chk("t4_clr_att0", a_att, 0);
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        chk("t4_att1", a_att, 1);
        chk("t4_no_lock", a_locked, 0);
        a_clr = 1'b1;
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        chk("t4_clr_and_req", a_att, 1);
        req_a(16'h1234, 16'h2341, 1'b1, 1'b0);

        // inputs changed during compare are ignored
        req_a(16'h1234, 16'h2341, 1'b1, 1'b1);
        req_a(16'h1235, 16'h2341, 1'b0, 1'b1);
        chk("t5_att1", a_att, 1);

        // reset mid-compare
        a_in = 16'h1234; a_st = 16'h2341; a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_busy", a_busy, 0);
        chk("t6_done", a_done, 0);
        chk("t6_att", a_att, 0);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            nd += int'(a_done);
            @(negedge clk);
        end
        chk("t6_no_done", nd, 0);
        chk("t6_idle", a_busy, 0);

        // reset mid-lockout
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        req_a(16'h1235, 16'h2341, 1'b0, 1'b0);
        chk("t6_locked", a_locked, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_lk_locked", a_locked, 0);
        chk("t6_lk_busy", a_busy, 0);
        chk("t6_lk_att", a_att, 0);
        rst_n = 1'b1;
        req_a(16'h1234, 16'h2341, 1'b1, 1'b0);
        chk("t6_after_att", a_att, 0);

        // 6-digit, ROT=2, single-failure lockout of 2 cycles
        req_b(24'h123456, 24'h345612, 1'b1);
        chk("b_att0", b_att, 0);
        chk("b_idle", b_busy, 0);
        req_b(24'h123457, 24'h345612, 1'b0);
        chk("b_locked1", b_locked, 1);
        chk("b_att1", b_att, 1);
        @(negedge clk);
        chk("b_locked2", b_locked, 1);
        @(negedge clk);
        chk("b_unlocked", b_locked, 0);
        chk("b_att_clr", b_att, 0);
        chk("b_idle2", b_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
